branch_compare_seq: RTL and testbench
=====================================

Name: branch_compare_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle branch comparator in the ALU.
- Compares accumulator operand `a` against operand `b` MSB-first, CHUNK bits per clock, with unsigned or signed mode.
- Produces registered EQ/GT/LT flags and a branch-taken decision from a condition code.
- Sits between the ALU operand path and the branch/PC-select logic, behind a valid/ready request and a one-cycle result strobe.

Parameters:
- WIDTH, 8, operand width in bits.
- CHUNK, 4, bits compared per cycle; must divide WIDTH; CHUNK==WIDTH gives one compare cycle.
- NCHUNK, WIDTH/CHUNK, derived localparam (not overridable); number of compare cycles.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- a  in  WIDTH  accumulator operand, sampled on accept.
- b  in  WIDTH  second operand, sampled on accept.
- is_signed  in  1  1 = two's-complement compare, sampled on accept.
- cond  in  3  branch condition code, sampled on accept.
- flush  in  1  synchronous abort of an in-flight compare.
- res_valid  out  1  one-cycle strobe, result valid.
- bc_flags  out  BC_FLAG_COUNT  {LT,GT,EQ} of a relative to b; held until next result.
- taken  out  1  branch decision for the latched cond; held with bc_flags.

Behaviour:
- Reset (async, any state): state=IDLE, req_ready=1, res_valid=0, bc_flags=0, taken=0, chunk counter=0, operand registers=0.
- Accept: occurs on a rising edge with req_valid && req_ready. On accept, latch a, b, is_signed and cond.
  - Signed mode: the MSB of both latched operands is inverted, so the compare itself is always unsigned.
  - Clear the decided and gt_bit flags; set counter=0; go to CMP.
- FSM states: IDLE, CMP, DONE.
  - IDLE: req_ready=1. Accept -> CMP.
  - CMP: req_ready=0. Each edge processes chunk `counter`, with chunk 0 = MSBs. If not decided and the chunks differ: decided=1, gt_bit = (chunk_a > chunk_b); otherwise unchanged. Counter increments. On the edge processing chunk NCHUNK-1 -> DONE.
  - DONE: res_valid=1 for exactly this cycle; req_ready=1. Accept -> CMP (back-to-back); otherwise -> IDLE.
- Flag update (on the CMP->DONE edge):
  - EQ = ~decided.
  - GT = decided & gt_bit.
  - LT = decided & ~gt_bit.
  - Exactly one flag is set.
- Outputs hold: bc_flags and taken keep their values through IDLE and the next CMP until the next DONE.
- Latency: accept at edge T -> res_valid high in the cycle following edge T+NCHUNK. Throughput is one result per NCHUNK+1 cycles.
- cond encoding (branch taken when):
  - 0 EQ: EQ
  - 1 NE: ~EQ
  - 2 LT: LT
  - 3 GE: ~LT
  - 4 GT: GT
  - 5 LE: ~GT
  - 6 ALWAYS: 1
  - 7 NEVER: 0
- flush:
  - In CMP: next state IDLE; no res_valid; flags and taken unchanged.
  - In DONE: suppresses a simultaneous accept; res_valid still asserts this cycle; next state IDLE.
  - In IDLE: ignored and blocks accept that cycle.
- Reset mid-CMP: immediate return to reset values; no res_valid afterwards.
- Inputs a/b/cond/is_signed changing while in CMP have no effect.
- Boundaries: all-zero vs all-ones operands; equality across every chunk; difference only in the last chunk (decided on the final edge); NCHUNK=1.

Decomposition:
- Shared defines header:
  - BC_FLAG_COUNT (3), BC_FLAG_EQ (0), BC_FLAG_GT (1), BC_FLAG_LT (2).
  - BC_COND_* codes 0-7.
  - FSM state encodings.
- One sub-module: branch_chunk_cmp (combinational, CHUNK-wide; outputs ne, a_gt). It is instantiated once and muxed by the counter.

Test Plan:
- Equal operands: WIDTH=8, CHUNK=4, a=0x5A, b=0x5A, unsigned, cond=EQ, accept at edge T -> res_valid in the cycle after edge T+2; bc_flags EQ=1, GT=0, LT=0; taken=1.
- Sign mode: a=0x80, b=0x7F, unsigned -> GT=1; same operands signed -> LT=1; with cond=LT signed, taken=1; with cond=GE, taken=0.
- Last-chunk difference: a=0x34, b=0x39 -> first chunk equal, second decides; LT=1, cond=LE gives taken=1. Also a=0xFF, b=0x00 -> GT=1.
- Back-to-back: second request held valid during DONE -> accepted that edge; second res_valid exactly 3 cycles after the first; first flags held until then.
- Flush and reset:
  - flush asserted in the first CMP cycle -> no res_valid, req_ready=1 next cycle, previous flags retained.
  - rst asserted mid-CMP -> all outputs 0 immediately, req_ready=1.
- Parameter variants: CHUNK=8 -> res_valid in the cycle after edge T+1 for a=0x01, b=0x02 (LT=1). WIDTH=16, CHUNK=4 -> latency 4 for a=0x1234, b=0x1235 (LT=1).

Source files
------------

// File: rtl/branch_compare_seq_pkg.sv
// Shared flag positions, branch condition codes and FSM encoding for the
// multi-cycle branch comparator.
package branch_compare_seq_pkg;

    localparam int BC_FLAG_COUNT = 3;
    localparam int BC_FLAG_EQ    = 0;
    localparam int BC_FLAG_GT    = 1;
    localparam int BC_FLAG_LT    = 2;

    localparam logic [2:0] BC_COND_EQ     = 3'd0;
    localparam logic [2:0] BC_COND_NE     = 3'd1;
    localparam logic [2:0] BC_COND_LT     = 3'd2;
    localparam logic [2:0] BC_COND_GE     = 3'd3;
    localparam logic [2:0] BC_COND_GT     = 3'd4;
    localparam logic [2:0] BC_COND_LE     = 3'd5;
    localparam logic [2:0] BC_COND_ALWAYS = 3'd6;
    localparam logic [2:0] BC_COND_NEVER  = 3'd7;

    typedef enum logic [1:0] {
        BC_ST_IDLE = 2'd0,
        BC_ST_CMP  = 2'd1,
        BC_ST_DONE = 2'd2
    } bc_state_t;

    function automatic logic bc_eval_cond(input logic [2:0] cond,
                                          input logic [BC_FLAG_COUNT-1:0] flags);
        logic taken;
        case (cond)
            BC_COND_EQ:     taken = flags[BC_FLAG_EQ];
            BC_COND_NE:     taken = ~flags[BC_FLAG_EQ];
            BC_COND_LT:     taken = flags[BC_FLAG_LT];
            BC_COND_GE:     taken = ~flags[BC_FLAG_LT];
            BC_COND_GT:     taken = flags[BC_FLAG_GT];
            BC_COND_LE:     taken = ~flags[BC_FLAG_GT];
            BC_COND_ALWAYS: taken = 1'b1;
            default:        taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_chunk_cmp.sv
// Combinational CHUNK-wide unsigned compare: reports inequality and a > b.
module branch_chunk_cmp #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] chunk_a,
    input  logic [CHUNK-1:0] chunk_b,
    output logic             ne,
    output logic             a_gt
);

    assign ne   = (chunk_a != chunk_b);
    assign a_gt = (chunk_a > chunk_b);

endmodule

// File: rtl/branch_compare_seq.sv
// Multi-cycle MSB-first operand comparator producing EQ/GT/LT flags and a
// branch-taken decision, CHUNK bits per clock behind a valid/ready handshake.
module branch_compare_seq
    import branch_compare_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     is_signed,
    input  logic [2:0]               cond,
    input  logic                     flush,
    output logic                     res_valid,
    output logic [BC_FLAG_COUNT-1:0] bc_flags,
    output logic                     taken
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("branch_compare_seq: CHUNK must divide WIDTH");
    end

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    function automatic logic [WIDTH-1:0] fold_sign(input logic [WIDTH-1:0] v,
                                                   input logic            sgn);
        return sgn ? (v ^ MSB_MASK) : v;
    endfunction

    bc_state_t              state, state_d;
    logic [WIDTH-1:0]       a_q, b_q;
    logic [2:0]             cond_q;
    logic [CNT_W-1:0]       cnt;
    logic                   decided, gt_bit;
    logic                   accept, last_chunk;
    logic                   chunk_ne, chunk_gt;
    logic                   decided_d, gt_bit_d;
    logic [BC_FLAG_COUNT-1:0] flags_d;
    logic [CHUNK-1:0]       a_chunks [NCHUNK];
    logic [CHUNK-1:0]       b_chunks [NCHUNK];

    // Chunk 0 holds the MSBs so the first difference found decides the order.
    for (genvar i = 0; i < NCHUNK; i++) begin : g_chunks
        assign a_chunks[i] = a_q[WIDTH-1-i*CHUNK -: CHUNK];
        assign b_chunks[i] = b_q[WIDTH-1-i*CHUNK -: CHUNK];
    end

    branch_chunk_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .chunk_a (a_chunks[cnt]),
        .chunk_b (b_chunks[cnt]),
        .ne      (chunk_ne),
        .a_gt    (chunk_gt)
    );

    always_comb begin
        state_d    = state;
        req_ready  = 1'b0;
        res_valid  = 1'b0;
        accept     = 1'b0;
        last_chunk = (cnt == LAST_CNT);
        decided_d  = decided | chunk_ne;
        gt_bit_d   = (!decided && chunk_ne) ? chunk_gt : gt_bit;
        flags_d             = '0;
        flags_d[BC_FLAG_EQ] = ~decided_d;
        flags_d[BC_FLAG_GT] = decided_d & gt_bit_d;
        flags_d[BC_FLAG_LT] = decided_d & ~gt_bit_d;

        case (state)
            BC_ST_IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid & ~flush;
                if (accept) state_d = BC_ST_CMP;
            end
            BC_ST_CMP: begin
                if (flush)           state_d = BC_ST_IDLE;
                else if (last_chunk) state_d = BC_ST_DONE;
            end
            BC_ST_DONE: begin
                req_ready = 1'b1;
                res_valid = 1'b1;
                accept    = req_valid & ~flush;
                state_d   = accept ? BC_ST_CMP : BC_ST_IDLE;
            end
            default: state_d = BC_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BC_ST_IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            cond_q   <= '0;
            cnt      <= '0;
            decided  <= 1'b0;
            gt_bit   <= 1'b0;
            bc_flags <= '0;
            taken    <= 1'b0;
        end else if (accept) begin
            a_q     <= fold_sign(a, is_signed);
            b_q     <= fold_sign(b, is_signed);
            cond_q  <= cond;
            cnt     <= '0;
            decided <= 1'b0;
            gt_bit  <= 1'b0;
        end else if (state == BC_ST_CMP && !flush) begin
            decided <= decided_d;
            gt_bit  <= gt_bit_d;
            cnt     <= cnt + CNT_W'(1);
            if (last_chunk) begin
                bc_flags <= flags_d;
                taken    <= bc_eval_cond(cond_q, flags_d);
            end
        end
    end

endmodule

// File: tb/tb_branch_compare_seq.sv
// Bench for branch_compare_seq: table of compare vectors through a scoreboard,
// plus handshake, flush, reset and parameter-variant sequences.
module tb_branch_compare_seq;
    import branch_compare_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid, req_ready, is_signed, flush, res_valid, taken;
    logic [7:0] a, b;
    logic [2:0] cond, bc_flags;

    logic       c8_req_valid, c8_req_ready, c8_is_signed, c8_flush, c8_res_valid, c8_taken;
    logic [7:0] c8_a, c8_b;
    logic [2:0] c8_cond, c8_flags;

    logic        w16_req_valid, w16_req_ready, w16_is_signed, w16_flush, w16_res_valid, w16_taken;
    logic [15:0] w16_a, w16_b;
    logic [2:0]  w16_cond, w16_flags;

    branch_compare_seq #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .a(a), .b(b), .is_signed(is_signed), .cond(cond), .flush(flush),
        .res_valid(res_valid), .bc_flags(bc_flags), .taken(taken));

    branch_compare_seq #(.WIDTH(8), .CHUNK(8)) dut_c8 (
        .clk(clk), .rst(rst), .req_valid(c8_req_valid), .req_ready(c8_req_ready),
        .a(c8_a), .b(c8_b), .is_signed(c8_is_signed), .cond(c8_cond), .flush(c8_flush),
        .res_valid(c8_res_valid), .bc_flags(c8_flags), .taken(c8_taken));

    branch_compare_seq #(.WIDTH(16), .CHUNK(4)) dut_w16 (
        .clk(clk), .rst(rst), .req_valid(w16_req_valid), .req_ready(w16_req_ready),
        .a(w16_a), .b(w16_b), .is_signed(w16_is_signed), .cond(w16_cond), .flush(w16_flush),
        .res_valid(w16_res_valid), .bc_flags(w16_flags), .taken(w16_taken));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sgn;
        logic [2:0] cond;
        logic [2:0] flags;
        logic       taken;
    } vec_t;

    typedef struct {
        logic [2:0] flags;
        logic       taken;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];
    logic [2:0] last_flags = 3'b000;
    logic       last_taken = 1'b0;
    vec_t       vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: result strobe with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            check({name, " flags"}, {29'd0, bc_flags}, {29'd0, e.flags});
            check({name, " taken"}, {31'd0, taken}, {31'd0, e.taken});
            last_flags = e.flags;
            last_taken = e.taken;
        end
    endtask

    // Entered at the first falling edge after accept; returns at the strobe edge.
    task automatic wait_result(input string name, input int exp_lat);
        int k = 1;
        while (!res_valid && k < 12) begin
            @(negedge clk);
            k++;
        end
        check({name, " latency"}, k, exp_lat);
        if (res_valid) pop_check(name);
    endtask

    task automatic no_strobe(input string name, input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check(name, seen, 0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        check({name, " ready"}, {31'd0, req_ready}, 1);
        a = v.a; b = v.b; is_signed = v.sgn; cond = v.cond; req_valid = 1'b1;
        @(posedge clk);
        sb.push_back('{v.flags, v.taken});
        @(negedge clk);
        req_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        cond = 3'($urandom); is_signed = 1'($urandom);
        check({name, " hold"}, {29'd0, bc_flags}, {29'd0, last_flags});
        wait_result(name, 3);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst = 1'b1;
        req_valid = 0; a = 0; b = 0; is_signed = 0; cond = 0; flush = 0;
        c8_req_valid = 0; c8_a = 0; c8_b = 0; c8_is_signed = 0; c8_cond = 0; c8_flush = 0;
        w16_req_valid = 0; w16_a = 0; w16_b = 0; w16_is_signed = 0; w16_cond = 0; w16_flush = 0;

        vecs[0]  = '{8'h5A, 8'h5A, 1'b0, BC_COND_EQ,     3'b001, 1'b1};
        vecs[1]  = '{8'h80, 8'h7F, 1'b0, BC_COND_GT,     3'b010, 1'b1};
        vecs[2]  = '{8'h80, 8'h7F, 1'b1, BC_COND_LT,     3'b100, 1'b1};
        vecs[3]  = '{8'h80, 8'h7F, 1'b1, BC_COND_GE,     3'b100, 1'b0};
        vecs[4]  = '{8'h34, 8'h39, 1'b0, BC_COND_LE,     3'b100, 1'b1};
        vecs[5]  = '{8'hFF, 8'h00, 1'b0, BC_COND_NE,     3'b010, 1'b1};
        vecs[6]  = '{8'h00, 8'hFF, 1'b0, BC_COND_GE,     3'b100, 1'b0};
        vecs[7]  = '{8'h00, 8'hFF, 1'b1, BC_COND_GT,     3'b010, 1'b1};
        vecs[8]  = '{8'hA5, 8'hA5, 1'b1, BC_COND_NEVER,  3'b001, 1'b0};
        vecs[9]  = '{8'h12, 8'h34, 1'b0, BC_COND_ALWAYS, 3'b100, 1'b1};
        vecs[10] = '{8'hFE, 8'hFF, 1'b1, BC_COND_LE,     3'b100, 1'b1};
        vecs[11] = '{8'h7F, 8'h80, 1'b1, BC_COND_NE,     3'b010, 1'b1};

        repeat (2) @(negedge clk);
        check("reset req_ready", {31'd0, req_ready}, 1);
        check("reset res_valid", {31'd0, res_valid}, 0);
        check("reset flags", {29'd0, bc_flags}, 0);
        check("reset taken", {31'd0, taken}, 0);
        check("reset c8 ready", {31'd0, c8_req_ready}, 1);
        check("reset w16 ready", {31'd0, w16_req_ready}, 1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: second request waits through CMP and is taken in DONE.
        a = 8'h5A; b = 8'h5B; is_signed = 0; cond = BC_COND_LT; req_valid = 1;
        @(posedge clk);
        sb.push_back('{3'b100, 1'b1});
        @(negedge clk);
        a = 8'h3C; b = 8'hC3; is_signed = 1; cond = BC_COND_GT;
        wait_result("b2b first", 3);
        @(posedge clk);
        sb.push_back('{3'b010, 1'b1});
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = 0;
            check($sformatf("b2b strobe c%0d", i), {31'd0, res_valid}, (i == 3) ? 1 : 0);
            if (i < 3) check($sformatf("b2b held c%0d", i), {29'd0, bc_flags}, 3'b100);
        end
        if (res_valid) pop_check("b2b second");
        @(negedge clk);

        // Flush in first CMP cycle.
        a = 8'h00; b = 8'hFF; is_signed = 0; cond = BC_COND_EQ; req_valid = 1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; flush = 1;
        @(negedge clk);
        flush = 0;
        check("flush cmp res_valid", {31'd0, res_valid}, 0);
        check("flush cmp ready", {31'd0, req_ready}, 1);
        check("flush cmp flags", {29'd0, bc_flags}, {29'd0, last_flags});
        check("flush cmp taken", {31'd0, taken}, {31'd0, last_taken});
        no_strobe("flush cmp no strobe", 4);

        // Flush in DONE suppresses a simultaneous accept.
        a = 8'h10; b = 8'h20; is_signed = 0; cond = BC_COND_NE; req_valid = 1;
        @(posedge clk);
        sb.push_back('{3'b100, 1'b1});
        @(negedge clk);
        req_valid = 0;
        wait_result("flush done", 3);
        flush = 1; req_valid = 1; a = 8'h01; b = 8'h02;
        #1;
        check("flush done strobe", {31'd0, res_valid}, 1);
        @(negedge clk);
        flush = 0; req_valid = 0;
        check("flush done no accept", {31'd0, req_ready}, 1);
        no_strobe("flush done no strobe", 4);

        // Flush in IDLE blocks the accept.
        req_valid = 1; flush = 1;
        @(negedge clk);
        check("flush idle no accept", {31'd0, req_ready}, 1);
        req_valid = 0; flush = 0;
        no_strobe("flush idle no strobe", 4);

        // CHUNK == WIDTH: single compare cycle.
        c8_a = 8'h01; c8_b = 8'h02; c8_cond = BC_COND_LT; c8_req_valid = 1;
        @(posedge clk);
        @(negedge clk);
        c8_req_valid = 0;
        k = 1;
        while (!c8_res_valid && k < 12) begin @(negedge clk); k++; end
        check("c8 latency", k, 2);
        check("c8 flags", {29'd0, c8_flags}, 3'b100);
        check("c8 taken", {31'd0, c8_taken}, 1);
        @(negedge clk);

        // WIDTH=16: four compare cycles, decided in the last chunk.
        w16_a = 16'h1234; w16_b = 16'h1235; w16_cond = BC_COND_EQ; w16_req_valid = 1;
        @(posedge clk);
        @(negedge clk);
        w16_req_valid = 0;
        k = 1;
        while (!w16_res_valid && k < 12) begin @(negedge clk); k++; end
        check("w16 latency", k, 5);
        check("w16 flags", {29'd0, w16_flags}, 3'b100);
        check("w16 taken", {31'd0, w16_taken}, 0);
        @(negedge clk);
        w16_a = 16'h8000; w16_b = 16'h0001; w16_is_signed = 1; w16_cond = BC_COND_LT; w16_req_valid = 1;
        @(posedge clk);
        @(negedge clk);
        w16_req_valid = 0;
        k = 1;
        while (!w16_res_valid && k < 12) begin @(negedge clk); k++; end
        check("w16 signed latency", k, 5);
        check("w16 signed flags", {29'd0, w16_flags}, 3'b100);
        check("w16 signed taken", {31'd0, w16_taken}, 1);
        @(negedge clk);

        // Asynchronous reset in the middle of a compare.
        check("pre-reset flags nonzero", {31'd0, (bc_flags != 3'b000)}, 1);
        a = 8'hFF; b = 8'h00; is_signed = 0; cond = BC_COND_GT; req_valid = 1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; rst = 1;
        #1;
        check("mid reset ready", {31'd0, req_ready}, 1);
        check("mid reset res_valid", {31'd0, res_valid}, 0);
        check("mid reset flags", {29'd0, bc_flags}, 0);
        check("mid reset taken", {31'd0, taken}, 0);
        @(negedge clk);
        rst = 0;
        last_flags = 3'b000; last_taken = 1'b0;
        no_strobe("mid reset no strobe", 4);

        check("scoreboard drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
